mem_access: RTL and testbench

- Memory-access stage of the 5-stage RV64 pipeline, between execute and write-back.
- Takes the ALU-computed address and store data, and issues one request per instruction to the data-memory port over a ready/valid handshake.
- Aligns and sign- or zero-extends load data into `mem_load_data` for write-back.
- Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_access_if.sv | 26 ++
 rtl/mem_access_load_align.sv | 28 ++
 rtl/mem_access.sv | 120 ++++++++++++
 tb/tb_mem_access.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the RV64 memory-access stage.
// Holds the stage FSM state encoding, RV load/store funct3 codes,
// the base byte-enable pattern per access size and the alignment rule.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte enables for an access at offset 0; the size lives in funct3[1:0].
  function automatic logic [7:0] wstrb_base(input logic [2:0] funct3);
    logic [7:0] strb;
    case (funct3[1:0])
      2'b00:   strb = 8'h01;
      2'b01:   strb = 8'h03;
      2'b10:   strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

  // Natural alignment check; funct3 111 is not a legal access size.
  function automatic logic access_misaligned(input logic [2:0] funct3,
                                             input logic [2:0] off);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = off[0];
      F3_W, F3_WU: mis = |off[1:0];
      F3_D:        mis = |off;
      3'b111:      mis = 1'b1;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response port of the memory-access stage.
// Ports: req/we/addr/wdata/wstrb from stage to memory, ready/rvalid/rdata back.
// master = pipeline stage side, slave = memory side.
interface mem_access_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                dmem_req;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]   dmem_wdata;
  logic [DATA_W/8-1:0] dmem_wstrb;
  logic                dmem_ready;
  logic                dmem_rvalid;
  logic [DATA_W-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Load data alignment: shifts the addressed bytes down to bit 0 and extends.
// Ports: rdata (64-bit memory word), off (byte offset), funct3 -> load_data.
// Purely combinational.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] load_data
);
  logic [63:0] raw;

  assign raw = rdata >> {off, 3'b000};

  always_comb begin
    load_data = raw;
    case (funct3)
      F3_B:    load_data = {{56{raw[7]}},  raw[7:0]};
      F3_H:    load_data = {{48{raw[15]}}, raw[15:0]};
      F3_W:    load_data = {{32{raw[31]}}, raw[31:0]};
      F3_BU:   load_data = {56'd0, raw[7:0]};
      F3_HU:   load_data = {48'd0, raw[15:0]};
      F3_WU:   load_data = {32'd0, raw[31:0]};
      default: load_data = raw;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues one data-memory request per load/store and
// returns aligned, extended load data; non-memory ops complete in one cycle.
// Ports: pipeline side (enable/complete handshake, operands, results) and dmem.
module mem_access
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              complete,
  output logic [DATA_W-1:0] mem_load_data,
  output logic [ADDR_W-1:0] alu_result_out,
  output logic              misaligned,
  mem_access_if.master      dmem
);
  mem_state_e        state_q, state_d;
  logic              latch_en, capture_en;

  logic [ADDR_W-1:0] alu_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [2:0]        off_q;
  logic              mis_q;
  logic [DATA_W-1:0] load_q;
  logic [DATA_W-1:0] aligned;

  logic [2:0]        off_in;
  logic              mem_op;
  logic              mis_in;

  assign off_in = alu_result[2:0];
  assign mem_op = mem_read | mem_write;
  // Misalignment only matters for real memory ops; ALU funct3 values are arbitrary.
  assign mis_in = mem_op & access_misaligned(mem_funct3, off_in);

  load_align u_load_align (
    .rdata     (dmem.dmem_rdata),
    .off       (off_q),
    .funct3    (f3_q),
    .load_data (aligned)
  );

  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          latch_en = 1'b1;
          state_d  = (!mem_op || mis_in) ? DONE : REQ;
        end
      end
      REQ: begin
        // we_q low means load (a read+write collision is treated as a load).
        if (dmem.dmem_ready) state_d = we_q ? DONE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dmem.dmem_rvalid) begin
          capture_en = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      alu_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      mis_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        alu_q   <= alu_result;
        addr_q  <= {alu_result[ADDR_W-1:3], 3'b000};
        wdata_q <= store_data << {off_in, 3'b000};
        wstrb_q <= wstrb_base(mem_funct3) << off_in;
        we_q    <= mem_write & ~mem_read;
        f3_q    <= mem_funct3;
        off_q   <= off_in;
        mis_q   <= mis_in;
      end
      if (capture_en) load_q <= aligned;
      if (state_q == DONE && !enable) mis_q <= 1'b0;
    end
  end

  assign complete        = (state_q == DONE);
  assign misaligned      = mis_q;
  assign mem_load_data   = load_q;
  assign alu_result_out  = alu_q;
  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [63:0] alu = 64'd0;
  logic [63:0] sd = 64'd0;
  logic        complete;
  logic [63:0] mem_load_data;
  logic [63:0] alu_result_out;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  logic [63:0] last_load = 64'd0;
  logic [63:0] seen_addr, seen_wdata;
  logic [7:0]  seen_wstrb;
  logic        seen_req;

  mem_access_if dif ();

  mem_access dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_funct3     (f3),
    .alu_result     (alu),
    .store_data     (sd),
    .complete       (complete),
    .mem_load_data  (mem_load_data),
    .alu_result_out (alu_result_out),
    .misaligned     (misaligned),
    .dmem           (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (byte-level view of the rules) ----------
  function automatic int acc_size(input logic [2:0] fn);
    return 1 << fn[1:0];
  endfunction

  function automatic logic model_mis(input logic rd, input logic wr,
                                     input logic [2:0] fn, input logic [2:0] o);
    if (!(rd || wr)) return 1'b0;
    if (fn == 3'b111) return 1'b1;
    return (int'(o) % acc_size(fn)) != 0;
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [2:0] fn, input logic [2:0] o);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < acc_size(fn); i++)
      if (int'(o) + i < 8) s[int'(o) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [2:0] o);
    logic [63:0] w = 64'd0;
    for (int i = 0; i + int'(o) < 8; i++) w[8*(int'(o)+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] r, input logic [2:0] o,
                                             input logic [2:0] fn);
    logic [63:0] v = 64'd0;
    int n = acc_size(fn);
    for (int i = 0; i < n; i++)
      if (int'(o) + i < 8) v[8*i +: 8] = r[8*(int'(o)+i) +: 8];
    if (!fn[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- transaction driver with inline checks -------------------
  task automatic run_op(input string nm, input logic rd, input logic wr,
                        input logic [2:0] fn, input logic [63:0] addr,
                        input logic [63:0] sdat, input logic [63:0] rdat,
                        input int rdy_dly, input int rv_dly, input int hold);
    logic [2:0]  o;
    logic        mis;
    logic [63:0] exp_wd, exp_ad;
    logic [7:0]  exp_st;
    o      = addr[2:0];
    mis    = model_mis(rd, wr, fn, o);
    exp_wd = model_wdata(sdat, o);
    exp_st = model_wstrb(fn, o);
    exp_ad = {addr[63:3], 3'b000};
    seen_req = 1'b0;
    enable = 1'b1; mem_read = rd; mem_write = wr; f3 = fn; alu = addr; sd = sdat;
    tick();
    // operands must have been latched; scramble the live inputs
    alu = {$urandom, $urandom}; sd = {$urandom, $urandom}; f3 = 3'($urandom);
    if (!(rd || wr) || mis) begin
      checks++; if (complete !== 1'b1) begin errors++; $display("FAIL %s complete_fast: got %b want 1", nm, complete); end
      checks++; if (misaligned !== mis) begin errors++; $display("FAIL %s misaligned: got %b want %b", nm, misaligned, mis); end
      checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL %s no_req: got %b want 0", nm, dif.dmem_req); end
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        checks++; if (dif.dmem_req !== 1'b1) begin errors++; $display("FAIL %s req: got %b want 1", nm, dif.dmem_req); end
        checks++; if (dif.dmem_we !== (wr && !rd)) begin errors++; $display("FAIL %s we: got %b want %b", nm, dif.dmem_we, wr && !rd); end
        checks++; if (dif.dmem_addr !== exp_ad) begin errors++; $display("FAIL %s addr: got %h want %h", nm, dif.dmem_addr, exp_ad); end
        checks++; if (dif.dmem_wdata !== exp_wd) begin errors++; $display("FAIL %s wdata: got %h want %h", nm, dif.dmem_wdata, exp_wd); end
        checks++; if (dif.dmem_wstrb !== exp_st) begin errors++; $display("FAIL %s wstrb: got %h want %h", nm, dif.dmem_wstrb, exp_st); end
        checks++; if (complete !== 1'b0) begin errors++; $display("FAIL %s early_complete: got %b want 0", nm, complete); end
        if (i == rdy_dly) begin
          seen_req = dif.dmem_req; seen_addr = dif.dmem_addr;
          seen_wdata = dif.dmem_wdata; seen_wstrb = dif.dmem_wstrb;
          dif.dmem_ready = 1'b1;
        end
        tick();
      end
      dif.dmem_ready = 1'b0;
      checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL %s req_drop: got %b want 0", nm, dif.dmem_req); end
      if (rd) begin
        checks++; if (complete !== 1'b0) begin errors++; $display("FAIL %s wait_complete: got %b want 0", nm, complete); end
        for (int i = 1; i < rv_dly; i++) begin
          tick();
          checks++; if (complete !== 1'b0) begin errors++; $display("FAIL %s wait_complete: got %b want 0", nm, complete); end
        end
        dif.dmem_rvalid = 1'b1; dif.dmem_rdata = rdat;
        tick();
        dif.dmem_rvalid = 1'b0; dif.dmem_rdata = {$urandom, $urandom};
        last_load = model_load(rdat, o, fn);
      end
      checks++; if (complete !== 1'b1) begin errors++; $display("FAIL %s complete: got %b want 1", nm, complete); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL %s misaligned: got %b want 0", nm, misaligned); end
    end
    checks++; if (alu_result_out !== addr) begin errors++; $display("FAIL %s alu_out: got %h want %h", nm, alu_result_out, addr); end
    checks++; if (mem_load_data !== last_load) begin errors++; $display("FAIL %s load_data: got %h want %h", nm, mem_load_data, last_load); end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++; if (complete !== 1'b1) begin errors++; $display("FAIL %s hold_complete: got %b want 1", nm, complete); end
      checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL %s hold_req: got %b want 0", nm, dif.dmem_req); end
      checks++; if (misaligned !== mis) begin errors++; $display("FAIL %s hold_mis: got %b want %b", nm, misaligned, mis); end
      checks++; if (alu_result_out !== addr) begin errors++; $display("FAIL %s hold_alu: got %h want %h", nm, alu_result_out, addr); end
    end
    enable = 1'b0;
    tick();
    checks++; if (complete !== 1'b0) begin errors++; $display("FAIL %s idle_complete: got %b want 0", nm, complete); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL %s idle_mis: got %b want 0", nm, misaligned); end
    checks++; if (mem_load_data !== last_load) begin errors++; $display("FAIL %s retain_load: got %h want %h", nm, mem_load_data, last_load); end
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (complete !== 1'b0) begin errors++; $display("FAIL reset complete: got %b want 0", complete); end
    checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL reset req: got %b want 0", dif.dmem_req); end
    checks++; if ({mem_load_data, alu_result_out, misaligned} !== 129'd0) begin errors++; $display("FAIL reset outs: got %h %h %b want 0", mem_load_data, alu_result_out, misaligned); end
    checks++; if ({dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, dif.dmem_wstrb} !== 137'd0) begin errors++; $display("FAIL reset dmem: got %h %h %h want 0", dif.dmem_addr, dif.dmem_wdata, dif.dmem_wstrb); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lb_sign();
    run_op("lb", 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h00000000_80000000, 1, 2, 0);
    checks++; if (mem_load_data !== 64'hFFFFFFFF_FFFFFF80) begin errors++; $display("FAIL lb value: got %h want ffffffffffffff80", mem_load_data); end
  endtask

  task automatic test_sh_stall();
    run_op("sh", 1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 3, 0, 1);
    checks++; if (seen_req !== 1'b1 || seen_wstrb !== 8'hC0) begin errors++; $display("FAIL sh wstrb: got %h want c0", seen_wstrb); end
    checks++; if (seen_wdata !== 64'hBEEF0000_00000000) begin errors++; $display("FAIL sh wdata: got %h want beef000000000000", seen_wdata); end
    checks++; if (seen_addr !== 64'h2000) begin errors++; $display("FAIL sh addr: got %h want 2000", seen_addr); end
  endtask

  task automatic test_misaligned();
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 1, 2);
  endtask

  task automatic test_passthrough();
    run_op("add", 1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 64'h0, 0, 1, 3);
    checks++; if (alu_result_out !== 64'h1234) begin errors++; $display("FAIL add alu_out: got %h want 1234", alu_result_out); end
  endtask

  task automatic test_lwu();
    run_op("lwu", 1'b1, 1'b0, 3'b110, 64'h4004, 64'h0, 64'hF0000000_00000000, 0, 1, 0);
    checks++; if (mem_load_data !== 64'h00000000_F0000000) begin errors++; $display("FAIL lwu value: got %h want 00000000f0000000", mem_load_data); end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; mem_read = 1'b1; mem_write = 1'b0; f3 = 3'b011; alu = 64'h5008;
    tick();
    dif.dmem_ready = 1'b1;
    tick();
    dif.dmem_ready = 1'b0;
    reset = 1'b1; enable = 1'b0;
    #1;
    checks++; if (complete !== 1'b0 || dif.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_mid ctl: got %b %b want 0 0", complete, dif.dmem_req); end
    checks++; if ({mem_load_data, alu_result_out, misaligned} !== 129'd0) begin errors++; $display("FAIL rst_mid outs: got %h %h %b want 0", mem_load_data, alu_result_out, misaligned); end
    checks++; if ({dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, dif.dmem_wstrb} !== 137'd0) begin errors++; $display("FAIL rst_mid dmem: got %h %h want 0", dif.dmem_addr, dif.dmem_wstrb); end
    tick();
    reset = 1'b0; last_load = 64'd0;
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    dif.dmem_rvalid = 1'b0;
    checks++; if (complete !== 1'b0 || mem_load_data !== 64'd0) begin errors++; $display("FAIL stray_rvalid: got %b %h want 0 0", complete, mem_load_data); end
    tick();
    checks++; if (complete !== 1'b0 || dif.dmem_req !== 1'b0) begin errors++; $display("FAIL stray_idle: got %b %b want 0 0", complete, dif.dmem_req); end
    run_op("ld_after_rst", 1'b1, 1'b0, 3'b011, 64'h6010, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic rd, wr;
      logic [2:0] fn;
      kind = $urandom_range(0, 3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      fn = 3'($urandom_range(0, 7));
      if (wr && !rd && fn[2] && fn != 3'b111) fn[2] = 1'b0;
      run_op("rand", rd, wr, fn, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 3),
             $urandom_range(0, 2));
    end
  endtask

  initial begin
    dif.dmem_ready = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = 64'd0;
    test_reset();
    test_lb_sign();
    test_sh_stall();
    test_misaligned();
    test_passthrough();
    test_lwu();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
